// File: rtl/step_clock_pkg.sv
// Shared definitions for the CPU clock-step and reset sequencer:
// FSM state encoding, default timing constants and a width helper.
package step_clock_pkg;

   typedef enum logic [2:0] {
      HOLD_HI,
      HOLD_LO,
      IDLE,
      HIGH,
      LOW
   } state_e;

   localparam int unsigned DIV_DEF        = 8;
   localparam int unsigned DEB_CYCLES_DEF = 4;
   localparam int unsigned RST_CYCLES_DEF = 2;
   localparam int unsigned CNT_W_DEF      = 16;

   // Counter width able to hold 0..n-1, never less than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce counter and press pulse.
// Ports: clk_i, rst_ni (async, active-low), key_i (raw, active-low),
//   press_o (one-cycle pulse on the debounced 1->0 edge).
module key_debounce
   import step_clock_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_i,
   output logic press_o
);

   localparam int unsigned DW = cnt_w(DEB_CYCLES);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic          press_q;
   logic          press_d;
   logic [DW-1:0] cnt_q;
   logic [DW-1:0] cnt_d;

   // Counter tracks consecutive samples differing from the accepted level;
   // any agreeing sample restarts it.
   always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == DEB_LAST) begin
            level_d = sync2_q;
            press_d = ~sync2_q;
         end else begin
            cnt_d = cnt_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/step_clock_gen.sv
// Slow CPU clock and reset sequencer: reset-hold periods, single-step, free-run.
// Ports: fastclk, rst (async, active-low), KEY (raw, active-low), run_mode;
//   cpu_clk, cpu_rst, busy, cycle_count. Macro STEP_CYCLE_COUNT_EN builds the counter.
module step_clock_gen
   import step_clock_pkg::*;
#(
   parameter int unsigned DIV        = DIV_DEF,
   parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic             fastclk,
   input  logic             rst,
   input  logic             KEY,
   input  logic             run_mode,
   output logic             cpu_clk,
   output logic             cpu_rst,
   output logic             busy,
   output logic [CNT_W-1:0] cycle_count
);

   localparam int unsigned HALF = DIV / 2;
   localparam int unsigned PW   = cnt_w(HALF);
   localparam int unsigned RW   = cnt_w(RST_CYCLES + 1);
   localparam logic [PW-1:0] PH_LAST = PW'(HALF - 1);
   localparam logic [RW-1:0] RP_LAST = RW'(RST_CYCLES);

   state_e        state_q;
   state_e        state_d;
   logic [PW-1:0] ph_q;
   logic [PW-1:0] ph_d;
   logic [RW-1:0] rp_q;
   logic [RW-1:0] rp_d;
   logic          clk_q;
   logic          clk_d;
   logic          rstn_q;
   logic          rstn_d;
   logic          busy_q;
   logic          busy_d;
   logic          press;
   logic          ph_end;

   key_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) u_key (
      .clk_i  (fastclk),
      .rst_ni (rst),
      .key_i  (KEY),
      .press_o(press)
   );

   assign ph_end = (ph_q == PH_LAST);

   always_comb begin
      state_d = state_q;
      ph_d    = '0;
      rp_d    = rp_q;
      clk_d   = clk_q;
      rstn_d  = rstn_q;
      unique case (state_q)
         HOLD_LO: begin
            if (!ph_end) begin
               ph_d = ph_q + PW'(1);
            end else if (rp_q == RP_LAST) begin
               state_d = IDLE;
               clk_d   = 1'b0;
               rstn_d  = 1'b1;
            end else begin
               state_d = HOLD_HI;
               clk_d   = 1'b1;
               rp_d    = rp_q + RW'(1);
            end
         end
         HOLD_HI: begin
            if (!ph_end) begin
               ph_d = ph_q + PW'(1);
            end else begin
               state_d = HOLD_LO;
               clk_d   = 1'b0;
            end
         end
         IDLE: begin
            clk_d = 1'b0;
            // Presses arriving in any other state are simply dropped.
            if (run_mode || press) begin
               state_d = HIGH;
               clk_d   = 1'b1;
            end
         end
         HIGH: begin
            if (!ph_end) begin
               ph_d = ph_q + PW'(1);
            end else begin
               state_d = LOW;
               clk_d   = 1'b0;
            end
         end
         LOW: begin
            if (!ph_end) begin
               ph_d = ph_q + PW'(1);
            end else if (run_mode) begin
               state_d = HIGH;
               clk_d   = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = HOLD_LO;
            clk_d   = 1'b0;
         end
      endcase
      busy_d = (state_d == HOLD_HI) || (state_d == HOLD_LO) ||
               (((state_d == HIGH) || (state_d == LOW)) && !run_mode);
   end

   always_ff @(posedge fastclk or negedge rst) begin
      if (!rst) begin
         state_q <= HOLD_LO;
         ph_q    <= '0;
         rp_q    <= '0;
         clk_q   <= 1'b0;
         rstn_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ph_q    <= ph_d;
         rp_q    <= rp_d;
         clk_q   <= clk_d;
         rstn_q  <= rstn_d;
         busy_q  <= busy_d;
      end
   end

   assign cpu_clk = clk_q;
   assign cpu_rst = rstn_q;
   assign busy    = busy_q;

`ifdef STEP_CYCLE_COUNT_EN
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             cnt_inc;

   // Counts every HIGH entry, i.e. each cpu_clk rising edge after reset-hold.
   assign cnt_inc = (state_d == HIGH) && (state_q != HIGH);
   assign cnt_d   = cnt_inc ? cnt_q + CNT_W'(1) : cnt_q;

   always_ff @(posedge fastclk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cycle_count = cnt_q;
`else
   assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_step_clock_gen.sv
// Self-checking bench for step_clock_gen against a period-level reference model.
// Covers reset-hold, single step, bounce, random presses, free-run, async reset, wrap.
module tb_step_clock_gen;

   localparam int DIV  = 8;
   localparam int H    = DIV / 2;
   localparam int DEB  = 4;
   localparam int RSTC = 2;
   localparam int CW   = 4;
   localparam int TR   = (2 * RSTC + 1) * H;
`ifdef STEP_CYCLE_COUNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif

   logic          fastclk = 1'b0;
   logic          rst = 1'b0;
   logic          KEY = 1'b1;
   logic          run_mode = 1'b0;
   logic          cpu_clk;
   logic          cpu_rst;
   logic          busy;
   logic [CW-1:0] cycle_count;

   int errors = 0;
   int checks = 0;

   // reference model state
   int   c;
   int   hist[$];
   int   m_deb;
   int   m_press;
   int   m_active;
   int   ps;
   int   m_cnt;
   logic e_clk;
   logic e_rst;
   logic e_busy;

   step_clock_gen #(
      .DIV(DIV),
      .DEB_CYCLES(DEB),
      .RST_CYCLES(RSTC),
      .CNT_W(CW)
   ) dut (
      .fastclk    (fastclk),
      .rst        (rst),
      .KEY        (KEY),
      .run_mode   (run_mode),
      .cpu_clk    (cpu_clk),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .cycle_count(cycle_count)
   );

   always #5 fastclk = ~fastclk;

   function automatic int exp_cnt(int n);
      return (n % (1 << CW)) * CNT_ON;
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      c = 0;
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_back(1);
      m_deb    = 1;
      m_press  = 0;
      m_active = 0;
      ps       = 0;
      m_cnt    = 0;
      e_clk    = 1'b0;
      e_rst    = 1'b0;
      e_busy   = 1'b0;
   endtask

   // One rising edge of the spec-level model, using inputs stable at that edge.
   task automatic model_step();
      int all_diff;
      if (!rst) begin
         model_reset();
         return;
      end
      c++;
      hist.push_back(int'(KEY));
      void'(hist.pop_front());
      if (c < TR) begin
         e_clk  = ((c / H) % 2) == 1;
         e_rst  = 1'b0;
         e_busy = 1'b1;
      end else if (c == TR) begin
         e_clk  = 1'b0;
         e_rst  = 1'b1;
         e_busy = 1'b0;
      end else begin
         if (m_active != 0 && c == ps + DIV) begin
            if (run_mode) begin
               ps = c;
               m_cnt++;
            end else begin
               m_active = 0;
            end
         end else if (m_active == 0 && (run_mode || m_press != 0)) begin
            ps = c;
            m_active = 1;
            m_cnt++;
         end
         e_clk  = (m_active != 0) && ((c - ps) < H);
         e_rst  = 1'b1;
         e_busy = (m_active != 0) && !run_mode;
      end
      // debounced level flips once DEB synchronized samples all disagree
      all_diff = 1;
      for (int k = 2; k <= DEB + 1; k++)
         if (hist[hist.size() - 1 - k] == m_deb) all_diff = 0;
      m_press = (all_diff != 0 && m_deb == 1) ? 1 : 0;
      if (all_diff != 0) m_deb = 1 - m_deb;
   endtask

   task automatic chk_outputs(string tag);
      chk({tag, "_wave"}, {cpu_clk, cpu_rst, busy}, {e_clk, e_rst, e_busy});
      chk({tag, "_cnt"}, cycle_count, exp_cnt(m_cnt));
   endtask

   task automatic tick(string tag);
      @(posedge fastclk);
      model_step();
      #1;
      chk_outputs(tag);
   endtask

   task automatic ticks(string tag, int n);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   task automatic drive_key(logic v);
      @(negedge fastclk);
      KEY = v;
   endtask

   initial begin
      int n;
      int base;
      model_reset();
      #1;
      chk_outputs("reset0");
      ticks("reset", 3);

      // reset-hold sequence
      @(negedge fastclk);
      rst = 1'b1;
      ticks("hold", TR + 6);
      chk("idle_busy", busy, 0);
      chk("idle_rst", cpu_rst, 1);

      // clean single step with latency measurement and a long hold
      drive_key(1'b0);
      n = 0;
      do begin
         tick("step");
         n++;
      end while (!cpu_clk && n < 20);
      chk("press_lat", n, 7);
      ticks("held", 100);
      chk("held_cnt", cycle_count, exp_cnt(1));
      drive_key(1'b1);
      ticks("rel", 20);

      // bounce: toggle every 2 cycles for 20 cycles, then settle low
      for (int i = 0; i < 10; i++) begin
         drive_key(i[0] ? 1'b1 : 1'b0);
         ticks("bounce", 1);
         @(negedge fastclk);
         ticks("bounce", 1);
      end
      drive_key(1'b0);
      ticks("settle", 30);
      chk("bounce_cnt", cycle_count, exp_cnt(2));
      drive_key(1'b1);
      ticks("rel2", 20);

      // random bouncy presses, some landing mid-period
      for (int r = 0; r < 30; r++) begin
         n = $urandom_range(0, 8);
         for (int i = 0; i < n; i++) begin
            drive_key(1'($urandom_range(0, 1)));
            tick("rnd_b");
         end
         drive_key(1'b0);
         ticks("rnd_hold", $urandom_range(1, 25));
         drive_key(1'b1);
         ticks("rnd_gap", $urandom_range(1, 25));
      end
      ticks("rnd_tail", 30);

      // free run for 100 periods, then drop run_mode mid-HIGH
      base = m_cnt;
      @(negedge fastclk);
      run_mode = 1'b1;
      ticks("run", 100 * DIV);
      chk("run100", cycle_count, exp_cnt(base + 100));
      ticks("run", 2);
      chk("midhigh", cpu_clk, 1);
      @(negedge fastclk);
      run_mode = 1'b0;
      ticks("stop", DIV + 4);
      chk("stop_clk", cpu_clk, 0);
      chk("stop_busy", busy, 0);
      chk("stop_cnt", cycle_count, exp_cnt(base + 101));

      // async reset in the middle of HIGH
      @(negedge fastclk);
      run_mode = 1'b1;
      ticks("run2", 3);
      @(negedge fastclk);
      rst = 1'b0;
      run_mode = 1'b0;
      model_reset();
      #1;
      chk_outputs("async_rst");
      chk("async_clk", cpu_clk, 0);
      ticks("rst_low", 3);
      @(negedge fastclk);
      rst = 1'b1;
      ticks("hold2", TR + 3);

      // 17 clean steps: counter wraps past 2^CW-1
      for (int s = 0; s < 17; s++) begin
         drive_key(1'b0);
         ticks("w_press", 12);
         drive_key(1'b1);
         ticks("w_rel", 12);
      end
      chk("wrap17", cycle_count, exp_cnt(17));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/step_clock_gen.md
# step_clock_gen

Synthesizable clock-step and reset sequencer that produces the processor's slow `clk` and its active-low reset from the board's `fastclk`, a push-button `KEY` and a run/step switch. It sits between the board I/O and `integration`, and generates in hardware the `clk`/`rst`/`KEY` waveforms that the integration bench drives by hand. In step mode each debounced press yields exactly one full CPU clock period. In run mode the CPU clock free-runs at `fastclk`/`DIV`.

## Interface
- `DIV`, 8: `fastclk` cycles per `cpu_clk` period; even, ≥2.
- `DEB_CYCLES`, 4: consecutive stable `fastclk` samples needed to accept a `KEY` level change; ≥1.
- `RST_CYCLES`, 2: `cpu_clk` periods issued with `cpu_rst` held low after `rst` releases; ≥1.
- `CNT_W`, 16: width of `cycle_count`.

- `fastclk` in 1: the only clock; all state is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `KEY` in 1: raw push button, active-low, asynchronous to `fastclk`.
- `run_mode` in 1: 1 = free-run, 0 = single-step; quasi-static.
- `cpu_clk` out 1: registered, 50% duty, drives `integration` `clk`.
- `cpu_rst` out 1: registered, active-low reset for `integration`.
- `busy` out 1: high while a step period or the reset-hold sequence is in progress.
- `cycle_count` out `CNT_W`: count of `cpu_clk` rising edges since `cpu_rst` released.

## Operation
- Reset values: `cpu_clk`=0, `cpu_rst`=0, `busy`=0, `cycle_count`=0. The FSM resets to HOLD_LO and the debounced key resets to 1 (released).
- `KEY` path:
  - Two-flop synchronizer, then debounce counter. The debounced level changes only after `DEB_CYCLES` equal samples that differ from it.
  - A press is the 1→0 transition of the debounced level, as a one-cycle pulse.
- FSM states: HOLD_HI, HOLD_LO, IDLE, HIGH, LOW. A phase counter counts `DIV/2` `fastclk` cycles per phase.
- HOLD_HI/HOLD_LO: `cpu_clk` toggles every `DIV/2` cycles with `cpu_rst`=0. After `RST_CYCLES` complete periods, at the end of a HOLD_LO phase, `cpu_rst`←1 and the FSM goes to IDLE. `busy`=1 in both states.
- IDLE: `cpu_clk`=0.
  - If `run_mode`=1, go to HIGH.
  - Else, on a press pulse, go to HIGH.
  - Otherwise stay in IDLE.
- HIGH: `cpu_clk`=1 for `DIV/2` cycles, then go to LOW. `cycle_count` increments on HIGH entry.
- LOW: `cpu_clk`=0 for `DIV/2` cycles. At phase end, go to HIGH if `run_mode`=1, otherwise go to IDLE.
- `busy`=1 in HIGH/LOW when `run_mode`=0.
- Boundary conditions:
  - A press during HOLD_*, HIGH or LOW is dropped, not queued.
  - A key held down yields one step only.
  - `run_mode` changes take effect only at a LOW phase end or in IDLE. A period is never truncated.
  - `cycle_count` wraps from 2^`CNT_W`−1 to 0.
  - Asserting `rst` mid-period forces reset values immediately. The sequence restarts at HOLD_LO when `rst` releases.

## Timing
- All outputs are registered; none is combinational from an input.
- Press latency: `KEY` falling edge → `cpu_clk` rising edge = 2 (sync) + `DEB_CYCLES` + 1 `fastclk` cycles, with no bounce.
- One step = exactly `DIV` `fastclk` cycles: `DIV/2` high then `DIV/2` low, ending low.
- `cpu_rst` rises one `fastclk` after the last HOLD_LO phase completes, while `cpu_clk`=0. The first `cpu_clk` rise is ≥1 `fastclk` later.
- `cycle_count` updates in the same cycle that `cpu_clk` goes 1.

## Configuration
- `STEP_CYCLE_COUNT_EN`:
  - Defined: the `cycle_count` register and incrementer are built.
  - Undefined: `cycle_count` is tied to 0 and no counter logic exists. All other behaviour is identical.

## Structure
- Shared package `step_clock_pkg` holds:
  - the FSM state encoding (HOLD_HI, HOLD_LO, IDLE, HIGH, LOW);
  - the default constants for `DIV`, `DEB_CYCLES` and `RST_CYCLES`.
- One sub-module, `key_debounce`: synchronizer, debounce counter and press-pulse generator. It is reusable for the other board buttons.

## Test plan
- Reset sequence, defaults, `run_mode`=0:
  - Release `rst` → exactly 2 `cpu_clk` periods of 8 `fastclk` each with `cpu_rst`=0.
  - Then `cpu_rst`=1 while `cpu_clk`=0, then IDLE with `busy`=0 and `cycle_count`=0.
- Single step: clean press → first `cpu_clk` rise 7 `fastclk` after `KEY` falls, one 4-high/4-low period, `cycle_count`=1. Key held 100 cycles → still 1.
- Bounce: `KEY` toggles every 2 cycles for 20 cycles, then settles low → exactly one step.
- Free run: `run_mode`=1 for 100 periods → continuous 8-cycle periods and `cycle_count`=100. Setting `run_mode`=0 mid-HIGH → that period completes, then IDLE.
- Wrap and reset: preload path with `CNT_W`=4, 17 steps → `cycle_count`=1. Assert `rst` in the middle of HIGH → `cpu_clk`=0, `cpu_rst`=0, `cycle_count`=0 immediately.
- Macro off: build without `STEP_CYCLE_COUNT_EN`, 5 steps → `cycle_count`=0 and all clock waveforms identical to the macro-on run.
